// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: owns PC, one outstanding imem read, registers iword
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] iword,
  output logic [31:0] iword_pc,
  output logic        iword_valid,
  input  logic        stall,
  input  logic        pc_select,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        capture;
  logic        consume;
  logic [31:0] redirect_pc;

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  // Misaligned branch targets are silently word-aligned.
  assign redirect_pc    = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    consume   = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (iword_valid && !stall) begin
          consume   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      iword       <= NOP_WORD;
      iword_pc    <= 32'h0000_0000;
      iword_valid <= 1'b0;
      instr_count <= 32'h0000_0000;
    end else if (capture) begin
      iword       <= imem_rsp_data;
      iword_pc    <= pc;
      iword_valid <= 1'b1;
    end else if (consume) begin
      pc          <= pc_select ? redirect_pc : iword_pc + 32'd4;
      iword       <= NOP_WORD;
      iword_valid <= 1'b0;
      instr_count <= instr_count + 32'd1;
    end
  end

endmodule
